// File: rtl/oj_judge_sequencer.sv
// Judge sequencer: holds both DUTs in reset, plays a latched bit pattern into them and compares outputs.
// done lands RST_CYCLES+PAT_LEN+DRAIN_CYCLES+1 cycles after start; start is only sampled in IDLE.
module oj_judge_sequencer #(
  parameter int RST_CYCLES   = 3,
  parameter int PAT_LEN      = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 8,
  parameter int IDX_W        = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               your_out,
  input  logic               ref_out,
  output logic               dut_rstn,
  output logic               stim,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [IDX_W-1:0]   first_fail
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cyc_q, cyc_d;
  logic [IDX_W-1:0]   idx_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ff_q, ff_d;
  logic               dut_rstn_q, stim_q, busy_q, done_q, pass_q;
  logic               accept, cmp_en, mis;

  always_comb begin
    accept  = (state_q == S_IDLE) && start;
    cmp_en  = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_DRAIN);
    mis     = cmp_en && (your_out != ref_out);
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start) state_d = S_RESET;
      end
      S_RESET: if (cyc_q == IDX_W'(RST_CYCLES - 1)) begin
        state_d = S_RUN;
        cyc_d   = '0;
      end
      S_RUN: if (cyc_q == IDX_W'(PAT_LEN - 1)) begin
        state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        cyc_d   = '0;
      end
      S_DRAIN: if (cyc_q == IDX_W'(DRAIN_CYCLES - 1)) begin
        state_d = S_DONE;
        cyc_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase

    // first_fail all-ones doubles as "no mismatch yet"; the index never reaches it.
    cnt_d = cnt_q;
    ff_d  = ff_q;
    if (accept) begin
      cnt_d = '0;
      ff_d  = '1;
    end else if (mis) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (ff_q == '1)  ff_d  = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      idx_q      <= '0;
      pat_q      <= '0;
      cnt_q      <= '0;
      ff_q       <= '1;
      dut_rstn_q <= 1'b0;
      stim_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      ff_q       <= ff_d;
      dut_rstn_q <= (state_d != S_RESET);
      busy_q     <= (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_DONE);
      if (accept) begin
        pat_q  <= pattern;
        idx_q  <= '0;
        pass_q <= 1'b0;
      end else begin
        if (cmp_en) idx_q <= idx_q + 1'b1;
        // Pattern shifts out LSB first, one bit per RUN cycle.
        if (state_d == S_RUN) pat_q <= pat_q >> 1;
      end
      stim_q <= (state_d == S_RUN) ? pat_q[0] : 1'b0;
      if (state_d == S_DONE) pass_q <= (cnt_d == '0);
    end
  end

  assign dut_rstn     = dut_rstn_q;
  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_oj_judge_sequencer.sv
// Bench for oj_judge_sequencer: scoreboard of expected run results, plus a 2-bit-counter instance that always mismatches.
module tb_oj_judge_sequencer;

  logic       clk, rstn, start, your_out, ref_out, your_out_s;
  logic [3:0] pattern;
  logic       dut_rstn, stim, busy, done, pass;
  logic [7:0] mismatch_cnt, first_fail;
  logic       s_dut_rstn, s_stim, s_busy, s_done, s_pass;
  logic [1:0] s_cnt;
  logic [7:0] s_ff;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] ff;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  assign your_out_s = ~ref_out;

  oj_judge_sequencer #(.RST_CYCLES(2), .PAT_LEN(4), .DRAIN_CYCLES(1), .CNT_W(8), .IDX_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern),
    .your_out(your_out), .ref_out(ref_out),
    .dut_rstn(dut_rstn), .stim(stim), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
  );

  oj_judge_sequencer #(.RST_CYCLES(2), .PAT_LEN(4), .DRAIN_CYCLES(1), .CNT_W(2), .IDX_W(8)) u_sat (
    .clk(clk), .rstn(rstn), .start(start), .pattern(pattern),
    .your_out(your_out_s), .ref_out(ref_out),
    .dut_rstn(s_dut_rstn), .stim(s_stim), .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch_cnt(s_cnt), .first_fail(s_ff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    n_vec++; if (dut_rstn !== 1'b0) begin n_err++; $display("FAIL %s dut_rstn got %b exp 0", tag, dut_rstn); end
    n_vec++; if (stim !== 1'b0) begin n_err++; $display("FAIL %s stim got %b exp 0", tag, stim); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy got %b exp 0", tag, busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done got %b exp 0", tag, done); end
    n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL %s pass got %b exp 0", tag, pass); end
    n_vec++; if (mismatch_cnt !== 8'd0) begin n_err++; $display("FAIL %s cnt got %0d exp 0", tag, mismatch_cnt); end
    n_vec++; if (first_fail !== 8'd255) begin n_err++; $display("FAIL %s first_fail got %0d exp 255", tag, first_fail); end
  endtask

  // One run from an IDLE cycle. flip[j] inverts your_out for comparison j.
  // abort_at >= 0 pulls rstn low during that comparison cycle.
  task automatic run(input logic [3:0] pat, input logic [6:0] flip, input bit hold,
                     input bit chg_pat, input int abort_at);
    exp_t e;
    int   n;
    logic exp_stim;
    n = 0;
    e.ff = 8'd255;
    for (int j = 6; j >= 0; j--) if (flip[j]) begin n++; e.ff = 8'(j); end
    e.cnt  = 8'(n);
    e.pass = (flip == 7'd0);
    sb.push_back(e);

    pattern = pat;
    start   = 1'b1;
    tick();
    start = hold;
    if (chg_pat) pattern = ~pat;
    n_vec++; if (mismatch_cnt !== 8'd0 || first_fail !== 8'd255 || pass !== 1'b0) begin
      n_err++; $display("FAIL clear_on_start got cnt=%0d ff=%0d pass=%b exp 0/255/0", mismatch_cnt, first_fail, pass);
    end

    for (int j = 0; j < 7; j++) begin
      ref_out  = 1'($urandom_range(0, 1));
      your_out = ref_out ^ flip[j];
      exp_stim = (j >= 2 && j <= 5) ? pat[j-2] : 1'b0;
      n_vec++; if (dut_rstn !== (j >= 2)) begin n_err++; $display("FAIL dut_rstn j=%0d got %b exp %b", j, dut_rstn, (j >= 2)); end
      n_vec++; if (stim !== exp_stim) begin n_err++; $display("FAIL stim j=%0d got %b exp %b", j, stim, exp_stim); end
      n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL busy_done j=%0d got %b%b exp 10", j, busy, done); end
      if (j == abort_at) begin
        rstn = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        n_vec++; if (s_busy !== 1'b0 || s_cnt !== 2'd0) begin n_err++; $display("FAIL midrun_reset_sat got busy=%b cnt=%0d exp 0/0", s_busy, s_cnt); end
        tick();
        tick();
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrun_no_done got done=%b busy=%b exp 0/0", done, busy); end
        rstn = 1'b1;
        tick();
        n_vec++; if (dut_rstn !== 1'b1) begin n_err++; $display("FAIL midrun_release dut_rstn got %b exp 1", dut_rstn); end
        void'(sb.pop_back());
        start = 1'b0;
        return;
      end
      tick();
    end

    e = sb.pop_front();
    n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL done_cycle got done=%b busy=%b exp 1/0", done, busy); end
    n_vec++; if (mismatch_cnt !== e.cnt) begin n_err++; $display("FAIL mismatch_cnt got %0d exp %0d", mismatch_cnt, e.cnt); end
    n_vec++; if (first_fail !== e.ff) begin n_err++; $display("FAIL first_fail got %0d exp %0d", first_fail, e.ff); end
    n_vec++; if (pass !== e.pass) begin n_err++; $display("FAIL pass got %b exp %b", pass, e.pass); end
    n_vec++; if (s_done !== 1'b1 || s_cnt !== 2'd3 || s_ff !== 8'd0 || s_pass !== 1'b0) begin
      n_err++; $display("FAIL saturation got done=%b cnt=%0d ff=%0d pass=%b exp 1/3/0/0", s_done, s_cnt, s_ff, s_pass);
    end
    tick();
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_done got done=%b busy=%b exp 0/0", done, busy); end
    n_vec++; if (mismatch_cnt !== e.cnt || first_fail !== e.ff || pass !== e.pass) begin
      n_err++; $display("FAIL held_results got %0d/%0d/%b exp %0d/%0d/%b", mismatch_cnt, first_fail, pass, e.cnt, e.ff, e.pass);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; pattern = 4'd0; your_out = 1'b0; ref_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rstn = 1'b1;
    #1;
    n_vec++; if (dut_rstn !== 1'b0) begin n_err++; $display("FAIL release_before_edge dut_rstn got %b exp 0", dut_rstn); end
    tick();
    n_vec++; if (dut_rstn !== 1'b1) begin n_err++; $display("FAIL release_edge dut_rstn got %b exp 1", dut_rstn); end
  endtask

  task automatic test_clean_run();
    run(4'b0101, 7'b0000000, 1'b0, 1'b0, -1);
  endtask

  task automatic test_mismatch_run();
    run(4'b1100, 7'b0101000, 1'b0, 1'b0, -1);
    tick();
    n_vec++; if (mismatch_cnt !== 8'd2 || first_fail !== 8'd3 || pass !== 1'b0) begin
      n_err++; $display("FAIL mismatch_hold got %0d/%0d/%b exp 2/3/0", mismatch_cnt, first_fail, pass);
    end
  endtask

  task automatic test_saturation();
    run(4'b1111, 7'b1111111, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run(4'b0011, 7'b0000000, 1'b1, 1'b1, -1);
    run(4'b1010, 7'b1000001, 1'b1, 1'b1, -1);
    start = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_not_queued busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_midrun();
    run(4'b0110, 7'b0000000, 1'b0, 1'b0, 3);
    run(4'b1001, 7'b0000010, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_mismatch_run();
    test_saturation();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
